// File: rtl/map_redraw_engine.sv
// Background redraw engine: rasters the selected background ROM into the VGA
// adapter on request and handshakes completion back to the game-state controller.
module map_redraw_engine #(
  parameter int WIDTH    = 320,
  parameter int HEIGHT   = 240,
  parameter int COLOUR_W = 9,
  parameter int ADDR_W   = 17
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                drawMap,
  input  logic [3:0]          gameState,
  input  logic [COLOUR_W-1:0] romColour,
  output logic [ADDR_W-1:0]   romAddr,
  output logic [2:0]          mapSel,
  output logic [8:0]          vgaX,
  output logic [7:0]          vgaY,
  output logic [COLOUR_W-1:0] vgaColour,
  output logic                vgaPlot,
  output logic                busy,
  output logic                doneRedraw
);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

  localparam logic [8:0]        X_LAST   = 9'(WIDTH - 1);
  localparam logic [7:0]        Y_LAST   = 8'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t     state;
  logic [8:0] xCnt;
  logic [7:0] yCnt;
  logic [8:0] plotX_p1;
  logic [7:0] plotY_p1;
  logic       vld_p1;
  logic [2:0] mapDecode;

  function automatic logic [2:0] decodeMap(input logic [3:0] code);
    logic [2:0] bank;
    case (code)
      4'd1, 4'd2:       bank = 3'd1;
      4'd3, 4'd4:       bank = 3'd2;
      4'd5, 4'd6:       bank = 3'd3;
      4'd7, 4'd8, 4'd9: bank = 3'd4;
      default:          bank = 3'd0;
    endcase
    return bank;
  endfunction

  assign mapDecode = decodeMap(gameState);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      xCnt       <= '0;
      yCnt       <= '0;
      romAddr    <= '0;
      mapSel     <= '0;
      plotX_p1   <= '0;
      plotY_p1   <= '0;
      vld_p1     <= 1'b0;
      busy       <= 1'b0;
      doneRedraw <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          vld_p1 <= 1'b0;
          if (drawMap) begin
            mapSel  <= mapDecode;
            xCnt    <= '0;
            yCnt    <= '0;
            romAddr <= '0;
            busy    <= 1'b1;
            state   <= SCAN;
          end
        end
        // p0 -> p1: coordinates of the issued address follow the ROM's read latency
        SCAN: begin
          plotX_p1 <= xCnt;
          plotY_p1 <= yCnt;
          vld_p1   <= 1'b1;
          if (xCnt == X_LAST && yCnt == Y_LAST) begin
            state <= FLUSH;
          end else begin
            romAddr <= romAddr + ADDR_ONE;
            if (xCnt == X_LAST) begin
              xCnt <= '0;
              yCnt <= yCnt + 8'd1;
            end else begin
              xCnt <= xCnt + 9'd1;
            end
          end
        end
        FLUSH: begin
          vld_p1     <= 1'b0;
          busy       <= 1'b0;
          doneRedraw <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (!drawMap) begin
            doneRedraw <= 1'b0;
            state      <= IDLE;
          end else if (mapDecode != mapSel) begin
            // Game state moved on while the controller still wants a map: redraw at once.
            mapSel     <= mapDecode;
            xCnt       <= '0;
            yCnt       <= '0;
            romAddr    <= '0;
            busy       <= 1'b1;
            doneRedraw <= 1'b0;
            state      <= SCAN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign vgaX      = plotX_p1;
  assign vgaY      = plotY_p1;
  assign vgaPlot   = vld_p1;
  assign vgaColour = vld_p1 ? romColour : '0;

endmodule

// File: tb/tb_map_redraw_engine.sv
// Directed and randomized bench for map_redraw_engine on a 4x3 frame with a
// registered ROM model and a raster-order plot reference.
module tb_map_redraw_engine;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int CW = 9;
  localparam int AW = 17;

  logic          clock = 1'b0;
  logic          resetn;
  logic          drawMap;
  logic [3:0]    gameState;
  logic [CW-1:0] romColour;
  logic [AW-1:0] romAddr;
  logic [2:0]    mapSel;
  logic [8:0]    vgaX;
  logic [7:0]    vgaY;
  logic [CW-1:0] vgaColour;
  logic          vgaPlot;
  logic          busy;
  logic          doneRedraw;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] romMem [0:4][0:N-1];
  int bankOf [16] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 4, 0, 0, 0, 0, 0, 0};

  map_redraw_engine #(.WIDTH(W), .HEIGHT(H), .COLOUR_W(CW), .ADDR_W(AW)) dut (
    .clock(clock), .resetn(resetn), .drawMap(drawMap), .gameState(gameState),
    .romColour(romColour), .romAddr(romAddr), .mapSel(mapSel), .vgaX(vgaX),
    .vgaY(vgaY), .vgaColour(vgaColour), .vgaPlot(vgaPlot), .busy(busy),
    .doneRedraw(doneRedraw)
  );

  always #5 clock = ~clock;

  function automatic logic [CW-1:0] romWord(input int bank, input int addr);
    if (bank < 0 || bank > 4 || addr < 0 || addr >= N) return '0;
    return romMem[bank][addr];
  endfunction

  // Registered ROM: data for an address appears one cycle after it is presented.
  always @(posedge clock) romColour <= romWord(int'(mapSel), int'(romAddr));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Inputs for the request must already be applied; the next edge is edge k.
  task automatic redraw(input int gs, input int dropAt, input bit scramble);
    int bank;
    int expAddr;
    bank = bankOf[gs];
    tick();
    check("start.busy", busy, 1);
    check("start.plot", vgaPlot, 0);
    check("start.done", doneRedraw, 0);
    check("start.mapSel", mapSel, bank);
    check("start.addr", romAddr, 0);
    for (int i = 0; i < N; i++) begin
      if (scramble) gameState = (i == N - 1) ? 4'(gs) : 4'($urandom_range(0, 15));
      tick();
      expAddr = (i < N - 1) ? i + 1 : N - 1;
      check("plot.vld", vgaPlot, 1);
      check("plot.x", vgaX, i % W);
      check("plot.y", vgaY, i / W);
      check("plot.colour", vgaColour, romMem[bank][i]);
      check("plot.addr", romAddr, expAddr);
      check("plot.busy", busy, 1);
      check("plot.done", doneRedraw, 0);
      check("plot.mapSel", mapSel, bank);
      if (i == dropAt) drawMap = 1'b0;
    end
    tick();
    check("end.done", doneRedraw, 1);
    check("end.plot", vgaPlot, 0);
    check("end.busy", busy, 0);
    check("end.mapSel", mapSel, bank);
  endtask

  task automatic releaseAndIdle();
    drawMap = 1'b0;
    tick();
    check("idle.done", doneRedraw, 0);
    check("idle.busy", busy, 0);
    check("idle.plot", vgaPlot, 0);
  endtask

  initial begin
    int gs;
    for (int b = 0; b < 5; b++)
      for (int a = 0; a < N; a++)
        romMem[b][a] = CW'($urandom);

    resetn    = 1'b1;
    drawMap   = 1'b0;
    gameState = 4'd0;
    #3 resetn = 1'b0;
    tick();
    tick();
    check("rst.plot", vgaPlot, 0);
    check("rst.busy", busy, 0);
    check("rst.done", doneRedraw, 0);
    check("rst.addr", romAddr, 0);
    check("rst.mapSel", mapSel, 0);
    check("rst.x", vgaX, 0);
    check("rst.y", vgaY, 0);
    check("rst.colour", vgaColour, 0);
    resetn = 1'b1;
    tick();

    // Small-frame raster from game state 10.
    gameState = 4'd10;
    drawMap   = 1'b1;
    redraw(10, -1, 1'b0);
    releaseAndIdle();

    // Bank decode with gameState scrambled mid-scan.
    foreach (bankOf[k]) begin
      if (k == 1 || k == 5 || k == 7) begin
        gameState = 4'(k);
        drawMap   = 1'b1;
        redraw(k, -1, 1'b1);
        releaseAndIdle();
      end
    end

    // Handshake hold.
    gameState = 4'd3;
    drawMap   = 1'b1;
    redraw(3, -1, 1'b0);
    for (int c = 0; c < 20; c++) begin
      tick();
      check("hold.done", doneRedraw, 1);
      check("hold.plot", vgaPlot, 0);
    end
    releaseAndIdle();
    tick();
    check("idle2.busy", busy, 0);

    // Restart from DONE when the decoded bank changes.
    gameState = 4'd2;
    drawMap   = 1'b1;
    redraw(2, -1, 1'b0);
    gameState = 4'd3;
    redraw(3, -1, 1'b0);
    releaseAndIdle();

    // Mid-scan drop: the scan completes and done pulses for one cycle.
    gameState = 4'd8;
    drawMap   = 1'b1;
    redraw(8, 4, 1'b0);
    tick();
    check("drop.done", doneRedraw, 0);
    check("drop.busy", busy, 0);
    tick();
    check("drop.idle", busy, 0);

    // Randomized redraws.
    for (int r = 0; r < 6; r++) begin
      gs        = int'($urandom_range(0, 15));
      gameState = 4'(gs);
      drawMap   = 1'b1;
      redraw(gs, -1, 1'b1);
      releaseAndIdle();
    end

    // Asynchronous reset mid-scan.
    gameState = 4'd5;
    drawMap   = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("pre.plot", vgaPlot, 1);
    #2 resetn = 1'b0;
    #1;
    check("arst.plot", vgaPlot, 0);
    check("arst.busy", busy, 0);
    check("arst.done", doneRedraw, 0);
    check("arst.addr", romAddr, 0);
    check("arst.mapSel", mapSel, 0);
    tick();
    check("arst.noplot", vgaPlot, 0);
    resetn = 1'b1;
    redraw(5, -1, 1'b0);
    releaseAndIdle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/map_redraw_engine.md
Name: map_redraw_engine

Overview:
- Downstream consumer of the game-state controller's drawMap/gameState outputs; produces the doneRedraw handshake that controller waits on.
- On request, scans the whole background: one pixel address per cycle into a background ROM selected by game state, and forwards each returned colour to the VGA adapter as a plot.
- Holds doneRedraw until the controller drops drawMap.

Parameters:
- WIDTH, 320, pixels per row; x counter range 0..WIDTH-1.
- HEIGHT, 240, rows; y counter range 0..HEIGHT-1.
- COLOUR_W, 9, colour bits from ROM to VGA.
- ADDR_W, 17, ROM address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- drawMap  in  1  redraw request level from the game-state controller.
- gameState  in  4  current game state code.
- romColour  in  COLOUR_W  ROM read data; registered ROM, valid the cycle after romAddr is presented.
- romAddr  out  ADDR_W  pixel address = y*WIDTH + x.
- mapSel  out  3  background ROM bank select, latched per redraw.
- vgaX  out  9  plot x coordinate.
- vgaY  out  8  plot y coordinate.
- vgaColour  out  COLOUR_W  plot colour (= romColour).
- vgaPlot  out  1  write strobe to the VGA adapter.
- busy  out  1  high in SCAN and FLUSH.
- doneRedraw  out  1  redraw-complete handshake.

Behaviour:
- Reset (async, resetn=0): state IDLE; x, y, romAddr = 0; mapSel = 0; vgaPlot, busy, doneRedraw = 0; vgaX, vgaY, vgaColour = 0.
- Map decode (combinational from gameState):
  - 10, 0 -> 0.
  - 1, 2 -> 1.
  - 3, 4 -> 2.
  - 5, 6 -> 3.
  - 7, 8, 9 -> 4.
  - Any other code -> 0.
- IDLE: when drawMap=1 at an edge -> latch mapSel from the decode, clear x, y, romAddr -> SCAN. Otherwise stay.
- SCAN, one address per cycle:
  - x increments; at x=WIDTH-1, x wraps to 0 and y increments.
  - romAddr increments by 1 using a running counter, not a multiplier.
  - At the edge where (x,y)=(WIDTH-1,HEIGHT-1) is current -> FLUSH; counters hold.
- Plot pipeline:
  - The x/y of each issued address is delayed 1 cycle alongside the ROM latency.
  - vgaPlot=1 and vgaX/vgaY/vgaColour are valid in the cycle after each address cycle.
  - Exactly WIDTH*HEIGHT plots per redraw, in raster order, with no gaps or duplicates.
- FLUSH: the last pixel is plotted this cycle -> DONE.
- DONE:
  - doneRedraw=1 registered; vgaPlot=0.
  - drawMap=0 -> IDLE, and doneRedraw falls at that edge.
  - drawMap=1 and decode != latched mapSel -> restart: latch new mapSel, clear counters -> SCAN, doneRedraw falls.
  - Otherwise hold.
- Latency: with drawMap sampled at edge k in IDLE, the first plot is in the cycle after edge k+1, and doneRedraw first goes high after edge k+WIDTH*HEIGHT+1.
- gameState and drawMap are ignored during SCAN/FLUSH. Dropping drawMap mid-scan does not abort; the scan completes, enters DONE for one cycle, then returns to IDLE.
- mapSel is stable from SCAN entry to DONE exit, except on a restart.
- Reset mid-scan: immediate return to reset values; no further plots.

Test Plan:
- Small-frame raster: WIDTH=4, HEIGHT=3. Reset, drawMap=1, gameState=10 -> 12 plots, (0,0),(1,0)..(3,2) in order; romAddr 0..11; mapSel=0; doneRedraw high after edge k+13.
- Bank decode: gameState=1, then 5, then 7 (one redraw each, drawMap toggled low between) -> mapSel = 1, 3, 4 respectively; vgaColour equals the model ROM word for each address, 1-cycle lag.
- Handshake hold: keep drawMap=1 for 20 cycles after done -> doneRedraw stays 1 and no plots occur; drop drawMap -> doneRedraw=0 next edge, state IDLE.
- Restart in DONE: during DONE with drawMap=1, change gameState 2->3 -> new scan with mapSel=2, doneRedraw=0, 12 further plots.
- Mid-scan drop: drawMap=0 after 5 plots -> all 12 plots still occur, doneRedraw pulses exactly 1 cycle.
- Async reset mid-scan: resetn=0 between edges -> vgaPlot, busy, doneRedraw = 0 immediately; after release with drawMap=1, the scan restarts at (0,0).
